// File: rtl/frame_parser_p.sv
// frame_parser_p: deframes HDR,HDR,CH,D0..Dn-1,CRC,TRL,TRL and packs good frames into one FIFO word.
// Optional macro FRAME_STATS_EN builds saturating good/bad frame counters.
module frame_parser_p #(
  parameter int DW = 16,
  parameter int MAX_WORDS = 8,
  parameter int NUM_CH = 8,
  parameter int CH_W = 8,
  parameter logic [DW-1:0] HDR_WORD = 16'hE0E0,
  parameter logic [DW-1:0] TRL_WORD = 16'h0E0E,
  parameter logic [DW-1:0] CRC_INIT = 16'h0000,
  localparam int CNT_W = $clog2(MAX_WORDS + 1),
  localparam int OW = MAX_WORDS * DW + CH_W + CNT_W
) (
  input  logic          clk_in,
  input  logic          rst_n,
  input  logic [DW-1:0] data_in,
  input  logic          fifo_full,
  output logic [OW-1:0] data_to_fifo,
  output logic          fifo_w_enable,
  output logic          crc_done,
  output logic          crc_err,
  output logic          len_err,
  output logic          ch_err,
  output logic          ovf_err,
  output logic [DW-1:0] data_to_crc,
  output logic [DW-1:0] crc,
  input  logic [DW-1:0] data_from_crc,
  output logic [15:0]   good_cnt,
  output logic [15:0]   bad_cnt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHAN  = 3'd1,
    FILL1 = 3'd2,
    FILL2 = 3'd3,
    DATA  = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [DW-1:0]           s0, s1, s2;
  logic [CNT_W-1:0]        count;
  logic                    first;
  logic [CH_W-1:0]         ch_sel;
  logic                    ch_bad;
  logic [MAX_WORDS*DW-1:0] payload;

  logic end_trl, end_ovr, take_word, start_frame;
  logic len_ev, ch_ev, crc_ev, good_ev, wr_ev, ovf_ev;

  // Handshake: no backpressure on data_in (one word per clk_in); fifo_w_enable is a
  // one-cycle strobe issued only when fifo_full is low in the frame-end cycle.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    end_trl     = 1'b0;
    end_ovr     = 1'b0;
    take_word   = 1'b0;
    start_frame = 1'b0;
    case (state)
      IDLE: begin
        if (s1 == HDR_WORD && s0 == HDR_WORD) begin
          state_nxt   = CHAN;
          start_frame = 1'b1;
        end
      end
      CHAN:  state_nxt = FILL1;
      FILL1: state_nxt = FILL2;
      FILL2: state_nxt = DATA;
      DATA: begin
        if (s1 == TRL_WORD && s0 == TRL_WORD) begin
          end_trl   = 1'b1;
          state_nxt = IDLE;
        end else if (count == CNT_W'(MAX_WORDS)) begin
          end_ovr   = 1'b1;
          state_nxt = IDLE;
        end else begin
          take_word = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Frame-end verdict: length beats channel beats CRC, so a bad frame raises exactly one error.
  always_comb begin
    len_ev  = end_ovr || (end_trl && count == '0);
    ch_ev   = end_trl && count != '0 && ch_bad;
    crc_ev  = end_trl && count != '0 && !ch_bad && (s2 != data_from_crc);
    good_ev = end_trl && count != '0 && !ch_bad && (s2 == data_from_crc);
    wr_ev   = good_ev && !fifo_full;
    ovf_ev  = good_ev && fifo_full;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      s0            <= '0;
      s1            <= '0;
      s2            <= '0;
      count         <= '0;
      first         <= 1'b0;
      ch_sel        <= '0;
      ch_bad        <= 1'b0;
      payload       <= '0;
      data_to_crc   <= '0;
      crc           <= CRC_INIT;
      data_to_fifo  <= '0;
      fifo_w_enable <= 1'b0;
      crc_done      <= 1'b0;
      crc_err       <= 1'b0;
      len_err       <= 1'b0;
      ch_err        <= 1'b0;
      ovf_err       <= 1'b0;
    end else begin
      s0 <= data_in;
      s1 <= s0;
      s2 <= s1;

      fifo_w_enable <= wr_ev;
      crc_done      <= end_trl || end_ovr;
      crc_err       <= crc_ev;
      len_err       <= len_ev;
      ch_err        <= ch_ev;
      ovf_err       <= ovf_ev;
      if (wr_ev) data_to_fifo <= {payload, ch_sel, count};

      if (state == IDLE) begin
        count       <= '0;
        first       <= 1'b1;
        crc         <= CRC_INIT;
        data_to_crc <= '0;
      end
      if (start_frame) payload <= '0;
      if (state == CHAN) begin
        ch_sel <= s0[CH_W-1:0];
        ch_bad <= (s0 >= DW'(NUM_CH));
      end

      // Word i lands directly in its left-aligned slot, so D0 always sits at the MSBs.
      if (take_word) begin
        for (int i = 0; i < MAX_WORDS; i++) begin
          if (count == CNT_W'(i)) payload[(MAX_WORDS-1-i)*DW +: DW] <= s2;
        end
        count       <= count + 1'b1;
        data_to_crc <= s2;
        crc         <= first ? CRC_INIT : data_from_crc;
        first       <= 1'b0;
      end
    end
  end

`ifdef FRAME_STATS_EN
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else begin
      if (fifo_w_enable && good_cnt != 16'hFFFF) good_cnt <= good_cnt + 1'b1;
      if ((crc_err || len_err || ch_err || ovf_err) && bad_cnt != 16'hFFFF)
        bad_cnt <= bad_cnt + 1'b1;
    end
  end
`else
  assign good_cnt = '0;
  assign bad_cnt  = '0;
`endif

endmodule

// File: tb/tb_frame_parser_p.sv
// Directed, table-driven bench for frame_parser_p with a CRC-16/CCITT engine model
// hooked to the data_to_crc/crc/data_from_crc loop.
module tb_frame_parser_p;

  localparam int DW = 16;
  localparam int MW = 8;
  localparam int CH_W = 8;
  localparam int CNT_W = 4;
  localparam int OW = MW * DW + CH_W + CNT_W;
  localparam logic [15:0] HDR = 16'hE0E0;
  localparam logic [15:0] TRL = 16'h0E0E;
  localparam logic [15:0] CINIT = 16'h0000;

  logic          clk_in = 1'b0;
  logic          rst_n;
  logic [DW-1:0] data_in;
  logic          fifo_full;
  logic [OW-1:0] data_to_fifo;
  logic          fifo_w_enable, crc_done, crc_err, len_err, ch_err, ovf_err;
  logic [DW-1:0] data_to_crc, crc, data_from_crc;
  logic [15:0]   good_cnt, bad_cnt;

  frame_parser_p dut (
    .clk_in(clk_in), .rst_n(rst_n), .data_in(data_in), .fifo_full(fifo_full),
    .data_to_fifo(data_to_fifo), .fifo_w_enable(fifo_w_enable), .crc_done(crc_done),
    .crc_err(crc_err), .len_err(len_err), .ch_err(ch_err), .ovf_err(ovf_err),
    .data_to_crc(data_to_crc), .crc(crc), .data_from_crc(data_from_crc),
    .good_cnt(good_cnt), .bad_cnt(bad_cnt)
  );

  // ---------------- clock ----------------
  always #5 clk_in = ~clk_in;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [15:0] d);
    logic [15:0] r;
    r = c ^ d;
    for (int i = 0; i < 16; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  assign data_from_crc = crc_step(crc, data_to_crc);

  // ---------------- monitor ----------------
  int n_wr = 0, n_done = 0, n_crc = 0, n_len = 0, n_ch = 0, n_ovf = 0, n_excl = 0;
  logic [OW-1:0] got_q[$];

  always @(negedge clk_in) begin
    if (fifo_w_enable) begin
      n_wr++;
      got_q.push_back(data_to_fifo);
    end
    if (crc_done) n_done++;
    if (crc_err) n_crc++;
    if (len_err) n_len++;
    if (ch_err) n_ch++;
    if (ovf_err) n_ovf++;
    if (fifo_w_enable && (crc_err || len_err || ch_err || ovf_err)) n_excl++;
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [OW-1:0] exp_q[$];
  int rd_idx = 0;
  int exp_good = 0, exp_bad = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drain_writes(input string name);
    logic [OW-1:0] e;
    while (rd_idx < got_q.size()) begin
      if (exp_q.size() == 0) begin
        chk({name, "_unexpected_write"}, got_q[rd_idx], '0);
      end else begin
        e = exp_q.pop_front();
        chk({name, "_fifo_word"}, got_q[rd_idx], e);
      end
      rd_idx++;
    end
    chk({name, "_missing_writes"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [15:0] ch;
    int          n;
    logic [15:0] w[9];
    logic [15:0] crc_xor;
    logic        full;
    logic        trl;
    int e_wr, e_done, e_crc, e_len, e_ch, e_ovf;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs[NV];

  task automatic set_vec(input int idx, input logic [15:0] ch, input int n,
                         input logic [15:0] base, input logic [15:0] step,
                         input logic [15:0] cx, input logic full, input logic trl,
                         input int ew, input int ed, input int ec, input int el,
                         input int ech, input int eo);
    vecs[idx].ch = ch;
    vecs[idx].n = n;
    for (int j = 0; j < 9; j++) vecs[idx].w[j] = base + step * 16'(j);
    vecs[idx].crc_xor = cx;
    vecs[idx].full = full;
    vecs[idx].trl = trl;
    vecs[idx].e_wr = ew;
    vecs[idx].e_done = ed;
    vecs[idx].e_crc = ec;
    vecs[idx].e_len = el;
    vecs[idx].e_ch = ech;
    vecs[idx].e_ovf = eo;
  endtask

  function automatic logic [OW-1:0] build_exp(input vec_t v);
    logic [OW-1:0] r;
    r = '0;
    for (int j = 0; j < v.n; j++) r[OW-1-16*j -: 16] = v.w[j];
    r[11:4] = v.ch[7:0];
    r[3:0] = 4'(v.n);
    return r;
  endfunction

  // ---------------- drivers ----------------
  task automatic send_word(input logic [15:0] w);
    @(posedge clk_in);
    #1 data_in = w;
  endtask

  task automatic send_body(input vec_t v);
    logic [15:0] c;
    c = CINIT;
    send_word(HDR);
    send_word(HDR);
    send_word(v.ch);
    for (int j = 0; j < v.n; j++) begin
      send_word(v.w[j]);
      c = crc_step(c, v.w[j]);
    end
    if (v.trl) begin
      send_word(c ^ v.crc_xor);
      send_word(TRL);
      send_word(TRL);
    end
  endtask

  task automatic send_frame(input vec_t v);
    fifo_full = v.full;
    send_body(v);
    repeat (6) send_word(16'h0000);
    fifo_full = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_w_enable"}, fifo_w_enable, 0);
    chk({name, "_crc_done"}, crc_done, 0);
    chk({name, "_errs"}, {crc_err, len_err, ch_err, ovf_err}, 0);
    chk({name, "_data_to_fifo"}, data_to_fifo, 0);
    chk({name, "_data_to_crc"}, data_to_crc, 0);
    chk({name, "_crc"}, crc, CINIT);
    chk({name, "_good_cnt"}, good_cnt, 0);
    chk({name, "_bad_cnt"}, bad_cnt, 0);
  endtask

  task automatic check_stats(input string name);
`ifdef FRAME_STATS_EN
    chk({name, "_good_cnt"}, good_cnt, exp_good);
    chk({name, "_bad_cnt"}, bad_cnt, exp_bad);
`else
    chk({name, "_good_cnt"}, good_cnt, 0);
    chk({name, "_bad_cnt"}, bad_cnt, 0);
`endif
  endtask

  // ---------------- test ----------------
  initial begin
    int s_wr, s_done, s_crc, s_len, s_ch, s_ovf;
    string nm;
    logic [OW-1:0] w0;

    //        idx ch  n  base     step     cx full trl  wr dn crc len ch ovf
    set_vec(0,  3, 8, 16'h0001, 16'h0001, 0, 0, 1,   1, 1, 0, 0, 0, 0);
    set_vec(1,  5, 2, 16'hAAAA, 16'hAAAB, 0, 0, 1,   1, 1, 0, 0, 0, 0);
    set_vec(2,  5, 2, 16'hAAAA, 16'hAAAB, 1, 0, 1,   0, 1, 1, 0, 0, 0);
    set_vec(3,  2, 0, 16'h0000, 16'h0000, 0, 0, 1,   0, 1, 0, 1, 0, 0);
    set_vec(4,  1, 1, 16'h1234, 16'h0000, 0, 0, 1,   1, 1, 0, 0, 0, 0);
    set_vec(5,  6, 9, 16'h0100, 16'h0101, 0, 0, 0,   0, 1, 0, 1, 0, 0);
    set_vec(6,  2, 3, 16'hBEEF, 16'h1111, 0, 0, 1,   1, 1, 0, 0, 0, 0);
    set_vec(7,  9, 1, 16'h0042, 16'h0000, 0, 0, 1,   0, 1, 0, 0, 1, 0);
    set_vec(8,  4, 2, 16'hC0DE, 16'h0001, 0, 1, 1,   0, 1, 0, 0, 0, 1);
    set_vec(9,  7, 1, 16'hFFFF, 16'h0000, 0, 0, 1,   1, 1, 0, 0, 0, 0);
    set_vec(10, 0, 4, HDR,      16'h0000, 0, 0, 1,   1, 1, 0, 0, 0, 0);

    // ---------------- reset ----------------
    rst_n = 1'b0;
    data_in = '0;
    fifo_full = 1'b0;
    repeat (3) @(posedge clk_in);
    #1 check_reset_outputs("reset");
    @(negedge clk_in) rst_n = 1'b1;

    // ---------------- table ----------------
    for (int i = 0; i < NV; i++) begin
      nm = $sformatf("v%0d", i);
      s_wr = n_wr; s_done = n_done; s_crc = n_crc;
      s_len = n_len; s_ch = n_ch; s_ovf = n_ovf;
      if (vecs[i].e_wr != 0) exp_q.push_back(build_exp(vecs[i]));
      exp_good += vecs[i].e_wr;
      exp_bad += vecs[i].e_crc + vecs[i].e_len + vecs[i].e_ch + vecs[i].e_ovf;
      send_frame(vecs[i]);
      chk({nm, "_wr"}, n_wr - s_wr, vecs[i].e_wr);
      chk({nm, "_done"}, n_done - s_done, vecs[i].e_done);
      chk({nm, "_crc_err"}, n_crc - s_crc, vecs[i].e_crc);
      chk({nm, "_len_err"}, n_len - s_len, vecs[i].e_len);
      chk({nm, "_ch_err"}, n_ch - s_ch, vecs[i].e_ch);
      chk({nm, "_ovf_err"}, n_ovf - s_ovf, vecs[i].e_ovf);
      drain_writes(nm);
      check_stats(nm);
      if (i == 0 && got_q.size() > 0) begin
        w0 = got_q[got_q.size()-1];
        chk("v0_hand_word", w0,
            {128'h0001_0002_0003_0004_0005_0006_0007_0008, 8'h03, 4'd8});
      end
      if (i == 1 && got_q.size() > 0) begin
        w0 = got_q[got_q.size()-1];
        chk("v1_top32", w0[139:108], 32'hAAAA5555);
        chk("v1_below_zero", w0[107:12], 0);
        chk("v1_count", w0[3:0], 2);
      end
    end
    chk("data_to_fifo_hold", data_to_fifo, build_exp(vecs[10]));

    // ---------------- back-to-back then mid-frame reset ----------------
    s_wr = n_wr; s_done = n_done;
    s_crc = n_crc + n_len + n_ch + n_ovf;
    exp_q.push_back(build_exp(vecs[4]));
    exp_q.push_back(build_exp(vecs[6]));
    send_body(vecs[4]);
    send_body(vecs[6]);
    send_word(HDR);
    send_word(HDR);
    send_word(16'h0003);
    send_word(16'h1111);
    send_word(16'h2222);
    send_word(16'h3333);
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    repeat (2) @(posedge clk_in);
    @(negedge clk_in) rst_n = 1'b1;
    exp_good = 0;
    exp_bad = 0;
    repeat (8) send_word(16'h0000);
    chk("b2b_wr", n_wr - s_wr, 2);
    chk("b2b_done", n_done - s_done, 2);
    chk("b2b_errs", n_crc + n_len + n_ch + n_ovf - s_crc, 0);
    drain_writes("b2b");
    check_stats("after_reset");

    // Parser must be usable again after the abandoned frame.
    s_wr = n_wr;
    exp_q.push_back(build_exp(vecs[0]));
    exp_good = 1;
    send_frame(vecs[0]);
    chk("post_reset_wr", n_wr - s_wr, 1);
    drain_writes("post_reset");
    check_stats("post_reset");
    chk("exclusive_pulses", n_excl, 0);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
